// File: rtl/addsub_rr_scheduler.sv
// Round-robin scheduler sharing one registered add/subtract unit between two
// FIFO-fed channels: pop an operand pair, register the result, push it out.
module addsub_rr_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int OP0        = 0,
  parameter int OP1        = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  ch0_inA_rd_en,
  input  logic                  ch0_inA_empty,
  input  logic [DATA_WIDTH-1:0] ch0_inA_dout,
  output logic                  ch0_inB_rd_en,
  input  logic                  ch0_inB_empty,
  input  logic [DATA_WIDTH-1:0] ch0_inB_dout,
  output logic                  ch0_out_wr_en,
  input  logic                  ch0_out_full,
  output logic [DATA_WIDTH-1:0] ch0_out_din,
  output logic                  ch1_inA_rd_en,
  input  logic                  ch1_inA_empty,
  input  logic [DATA_WIDTH-1:0] ch1_inA_dout,
  output logic                  ch1_inB_rd_en,
  input  logic                  ch1_inB_empty,
  input  logic [DATA_WIDTH-1:0] ch1_inB_dout,
  output logic                  ch1_out_wr_en,
  input  logic                  ch1_out_full,
  output logic [DATA_WIDTH-1:0] ch1_out_din,
  output logic [CNT_WIDTH-1:0]  grant_count0,
  output logic [CNT_WIDTH-1:0]  grant_count1
);

  typedef enum logic {S_SEL, S_WR} state_t;

  localparam logic OP0_SUB = (OP0 != 0);
  localparam logic OP1_SUB = (OP1 != 0);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] result;
  logic                  gnt, last;

  logic                  elig0, elig1, sel_valid, sel_ch, sel_op;
  logic [DATA_WIDTH-1:0] sel_a, sel_b, sel_res;
  logic                  out_full, load, write;

  // Arbitration and datapath; the alternate grant goes to the channel != last.
  always_comb begin
    elig0     = !ch0_inA_empty && !ch0_inB_empty;
    elig1     = !ch1_inA_empty && !ch1_inB_empty;
    sel_valid = elig0 || elig1;
    sel_ch    = (elig0 && elig1) ? !last : elig1;
    sel_a     = sel_ch ? ch1_inA_dout : ch0_inA_dout;
    sel_b     = sel_ch ? ch1_inB_dout : ch0_inB_dout;
    sel_op    = sel_ch ? OP1_SUB : OP0_SUB;
    sel_res   = sel_op ? (sel_a - sel_b) : (sel_a + sel_b);
    out_full  = gnt ? ch1_out_full : ch0_out_full;
    load      = !reset && (state == S_SEL) && sel_valid;
    write     = !reset && (state == S_WR) && !out_full;
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_next    = state;
    ch0_inA_rd_en = 1'b0;
    ch0_inB_rd_en = 1'b0;
    ch1_inA_rd_en = 1'b0;
    ch1_inB_rd_en = 1'b0;
    ch0_out_wr_en = 1'b0;
    ch1_out_wr_en = 1'b0;
    ch0_out_din   = '0;
    ch1_out_din   = '0;
    if (!reset) begin
      case (state)
        S_SEL: begin
          if (sel_valid) begin
            ch0_inA_rd_en = !sel_ch;
            ch0_inB_rd_en = !sel_ch;
            ch1_inA_rd_en = sel_ch;
            ch1_inB_rd_en = sel_ch;
            state_next    = S_WR;
          end
        end
        S_WR: begin
          // Output full stalls here; nothing is popped while a result waits.
          if (gnt) ch1_out_din = result;
          else     ch0_out_din = result;
          ch0_out_wr_en = write && !gnt;
          ch1_out_wr_en = write && gnt;
          if (write) state_next = S_SEL;
        end
        default: state_next = S_SEL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_SEL;
      result       <= '0;
      gnt          <= 1'b0;
      last         <= 1'b1;
      grant_count0 <= '0;
      grant_count1 <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        result <= sel_res;
        gnt    <= sel_ch;
      end
      if (write) begin
        last <= gnt;
        if (gnt) grant_count1 <= grant_count1 + CNT_WIDTH'(1);
        else     grant_count0 <= grant_count0 + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Directed bench for addsub_rr_scheduler: behavioural show-ahead FIFOs feed the
// DUT, results are logged, and each step compares against hand-computed values.
module tb_addsub_rr_scheduler;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int DEPTH = 1024;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ch0_inA_rd_en, ch0_inB_rd_en, ch0_out_wr_en;
  logic          ch1_inA_rd_en, ch1_inB_rd_en, ch1_out_wr_en;
  logic          ch0_inA_empty, ch0_inB_empty, ch1_inA_empty, ch1_inB_empty;
  logic [DW-1:0] ch0_inA_dout, ch0_inB_dout, ch1_inA_dout, ch1_inB_dout;
  logic [DW-1:0] ch0_out_din, ch1_out_din;
  logic          ch0_out_full = 1'b0;
  logic          ch1_out_full = 1'b0;
  logic [CW-1:0] grant_count0, grant_count1;

  always #5 clock = ~clock;

  addsub_rr_scheduler #(.DATA_WIDTH(DW), .OP0(0), .OP1(1), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .ch0_inA_rd_en(ch0_inA_rd_en), .ch0_inA_empty(ch0_inA_empty), .ch0_inA_dout(ch0_inA_dout),
    .ch0_inB_rd_en(ch0_inB_rd_en), .ch0_inB_empty(ch0_inB_empty), .ch0_inB_dout(ch0_inB_dout),
    .ch0_out_wr_en(ch0_out_wr_en), .ch0_out_full(ch0_out_full), .ch0_out_din(ch0_out_din),
    .ch1_inA_rd_en(ch1_inA_rd_en), .ch1_inA_empty(ch1_inA_empty), .ch1_inA_dout(ch1_inA_dout),
    .ch1_inB_rd_en(ch1_inB_rd_en), .ch1_inB_empty(ch1_inB_empty), .ch1_inB_dout(ch1_inB_dout),
    .ch1_out_wr_en(ch1_out_wr_en), .ch1_out_full(ch1_out_full), .ch1_out_din(ch1_out_din),
    .grant_count0(grant_count0), .grant_count1(grant_count1)
  );

  // Show-ahead FIFO models: write counts advance from the stimulus, read
  // pointers advance on the DUT's pops.
  logic [DW-1:0] m0a [DEPTH];
  logic [DW-1:0] m0b [DEPTH];
  logic [DW-1:0] m1a [DEPTH];
  logic [DW-1:0] m1b [DEPTH];
  int w0a = 0, w0b = 0, w1a = 0, w1b = 0;
  int r0a = 0, r0b = 0, r1a = 0, r1b = 0;

  assign ch0_inA_empty = (r0a == w0a);
  assign ch0_inB_empty = (r0b == w0b);
  assign ch1_inA_empty = (r1a == w1a);
  assign ch1_inB_empty = (r1b == w1b);
  assign ch0_inA_dout  = m0a[r0a % DEPTH];
  assign ch0_inB_dout  = m0b[r0b % DEPTH];
  assign ch1_inA_dout  = m1a[r1a % DEPTH];
  assign ch1_inB_dout  = m1b[r1b % DEPTH];

  always @(posedge clock) begin
    if (ch0_inA_rd_en) r0a <= r0a + 1;
    if (ch0_inB_rd_en) r0b <= r0b + 1;
    if (ch1_inA_rd_en) r1a <= r1a + 1;
    if (ch1_inB_rd_en) r1b <= r1b + 1;
  end

  int            log_ch[$];
  logic [DW-1:0] log_d[$];
  int            viol = 0;

  always @(posedge clock) begin
    if (ch0_out_wr_en) begin log_ch.push_back(0); log_d.push_back(ch0_out_din); end
    if (ch1_out_wr_en) begin log_ch.push_back(1); log_d.push_back(ch1_out_din); end
    if (!reset) begin
      if (ch0_inA_rd_en && ch0_inA_empty) viol++;
      if (ch0_inB_rd_en && ch0_inB_empty) viol++;
      if (ch1_inA_rd_en && ch1_inA_empty) viol++;
      if (ch1_inB_rd_en && ch1_inB_empty) viol++;
      if (ch0_inA_rd_en != ch0_inB_rd_en) viol++;
      if (ch1_inA_rd_en != ch1_inB_rd_en) viol++;
      if (ch0_out_wr_en && ch0_out_full)  viol++;
      if (ch1_out_wr_en && ch1_out_full)  viol++;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push0a(input logic [DW-1:0] a);
    m0a[w0a % DEPTH] = a; w0a++;
  endtask
  task automatic push0b(input logic [DW-1:0] b);
    m0b[w0b % DEPTH] = b; w0b++;
  endtask
  task automatic push0(input logic [DW-1:0] a, input logic [DW-1:0] b);
    push0a(a); push0b(b);
  endtask
  task automatic push1(input logic [DW-1:0] a, input logic [DW-1:0] b);
    m1a[w1a % DEPTH] = a; w1a++;
    m1b[w1b % DEPTH] = b; w1b++;
  endtask

  function automatic logic [3:0] rd_bits();
    return {ch0_inA_rd_en, ch0_inB_rd_en, ch1_inA_rd_en, ch1_inB_rd_en};
  endfunction

  initial begin
    // Reset with every FIFO non-empty: no strobes, then ch0 wins first.
    push0(1, 2);
    push1(10, 4);
    @(negedge clock);
    check("reset_rd", {28'd0, rd_bits()}, 32'h0);
    check("reset_wr", {30'd0, ch0_out_wr_en, ch1_out_wr_en}, 32'h0);
    check("reset_din", ch0_out_din | ch1_out_din, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("first_grant_ch0", {28'd0, rd_bits()}, 32'hC);
    check("reset_cnt0", {24'd0, grant_count0}, 32'd0);
    check("reset_cnt1", {24'd0, grant_count1}, 32'd0);
    @(negedge clock);
    check("first_wr_ch0", {31'd0, ch0_out_wr_en}, 32'd1);
    check("first_din_ch0", ch0_out_din, 32'd3);
    check("first_din_ch1_idle", ch1_out_din, 32'd0);
    @(negedge clock);
    check("second_grant_ch1", {28'd0, rd_bits()}, 32'h3);
    @(negedge clock);
    check("second_din_ch1", ch1_out_din, 32'd6);
    check("second_wr_ch1", {31'd0, ch1_out_wr_en}, 32'd1);
    @(negedge clock);
    check("idle_rd", {28'd0, rd_bits()}, 32'h0);

    // Single channel: 5 + 3 on ch0 only.
    push0(5, 3);
    #1;
    check("single_pop", {28'd0, rd_bits()}, 32'hC);
    @(negedge clock);
    check("single_din", ch0_out_din, 32'd8);
    check("single_wr", {30'd0, ch0_out_wr_en, ch1_out_wr_en}, 32'h2);
    @(negedge clock);
    check("single_cnt0", {24'd0, grant_count0}, 32'd2);

    // Arbitration: last grant was ch0, so ch1 leads and grants alternate.
    log_ch.delete();
    log_d.delete();
    for (int i = 0; i < 4; i++) begin
      push0(32'(3 * i), 100);
      push1(10, 4);
    end
    repeat (16) @(negedge clock);
    check("arb_writes", 32'(log_ch.size()), 32'd8);
    for (int k = 0; k < log_ch.size(); k++) begin
      check($sformatf("arb_ch_%0d", k), 32'(log_ch[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("arb_d_%0d", k), log_d[k], (k % 2 == 0) ? 32'd6 : 32'(100 + 3 * (k / 2)));
    end
    check("arb_cnt0", {24'd0, grant_count0}, 32'd6);
    check("arb_cnt1", {24'd0, grant_count1}, 32'd5);

    // Backpressure: ch1 result 20 - 7 = 13 held while its output is full.
    ch1_out_full = 1'b1;
    push1(20, 7);
    #1;
    check("bp_pop", {28'd0, rd_bits()}, 32'h3);
    @(negedge clock);
    push0(7, 7);
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_din_%0d", i), ch1_out_din, 32'd13);
      check($sformatf("bp_wr_%0d", i), {30'd0, ch0_out_wr_en, ch1_out_wr_en}, 32'h0);
      check($sformatf("bp_rd_%0d", i), {28'd0, rd_bits()}, 32'h0);
      @(negedge clock);
    end
    ch1_out_full = 1'b0;
    #1;
    check("bp_release_wr", {31'd0, ch1_out_wr_en}, 32'd1);
    check("bp_release_din", ch1_out_din, 32'd13);
    @(negedge clock);
    check("bp_next_grant_ch0", {28'd0, rd_bits()}, 32'hC);
    @(negedge clock);
    check("bp_next_din_ch0", ch0_out_din, 32'd14);
    @(negedge clock);
    check("bp_cnt0", {24'd0, grant_count0}, 32'd7);
    check("bp_cnt1", {24'd0, grant_count1}, 32'd6);

    // Partial data: ch0 has only A, so only ch1 (3 - 1) is served.
    push0a(9);
    push1(3, 1);
    #1;
    check("partial_grant_ch1", {28'd0, rd_bits()}, 32'h3);
    @(negedge clock);
    check("partial_din_ch1", ch1_out_din, 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("partial_no_pop_%0d", i), {28'd0, rd_bits()}, 32'h0);
    end
    push0b(4);
    #1;
    check("partial_b_arrives", {28'd0, rd_bits()}, 32'hC);
    @(negedge clock);
    check("partial_din_ch0", ch0_out_din, 32'd13);
    @(negedge clock);

    // Arithmetic wrap on both channels; ch1 goes first since ch0 was last.
    log_ch.delete();
    log_d.delete();
    push0(32'h7FFF_FFFF, 1);
    push1(32'h8000_0000, 1);
    repeat (4) @(negedge clock);
    check("wrap_writes", 32'(log_ch.size()), 32'd2);
    if (log_ch.size() == 2) begin
      check("wrap_ch1_first", 32'(log_ch[0]), 32'd1);
      check("wrap_sub", log_d[0], 32'h7FFF_FFFF);
      check("wrap_add", log_d[1], 32'h8000_0000);
    end
    check("wrap_cnt0", {24'd0, grant_count0}, 32'd9);
    check("wrap_cnt1", {24'd0, grant_count1}, 32'd8);

    // Counter wrap: 246 more ch0 grants reach all-ones, one more wraps to 0.
    for (int i = 0; i < 246; i++) push0(32'(i), 1);
    repeat (492) @(negedge clock);
    check("cnt0_all_ones", {24'd0, grant_count0}, 32'd255);
    push0(1, 1);
    repeat (2) @(negedge clock);
    check("cnt0_wrapped", {24'd0, grant_count0}, 32'd0);
    check("cnt1_unchanged", {24'd0, grant_count1}, 32'd8);

    check("protocol_violations", 32'(viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
